// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RAW hazard detection, flush and stall control for an in-order pipeline
module hazard_ctrl #(
    parameter int ADDR_WIDTH  = 5,
    parameter int NUM_STAGES  = 3,
    parameter int FWD_EN      = 1,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid_i,
    input  logic [ADDR_WIDTH-1:0] read_addr1_i,
    input  logic [ADDR_WIDTH-1:0] read_addr2_i,
    input  logic                  read_en1_i,
    input  logic                  read_en2_i,
    input  logic [ADDR_WIDTH-1:0] write_addr_i,
    input  logic                  write_en_i,
    input  logic                  is_load_i,
    input  logic                  flush_i,
    input  logic                  ext_stall_i,
    output logic                  pc_stall_o,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic [NUM_STAGES-1:0] clear_o,
    output logic                  hazard_o,
    output logic [CNT_WIDTH-1:0]  stall_count_o
);

    localparam int NS = NUM_STAGES;
    localparam logic [NS-1:0] ALL_ONES   = '1;
    localparam logic [NS-1:0] FLUSH_MASK = NS'((1 << FLUSH_DEPTH) - 1);

    logic [NS-1:1]         s_valid, s_we, s_ld;
    logic [ADDR_WIDTH-1:0] s_wa [NS-1:1];
    logic [NS-1:1]         p_valid, p_we, p_ld;
    logic [ADDR_WIDTH-1:0] p_wa [NS-1:1];
    logic                  raw;

    // Each slot's upstream source: slot 1 takes the decode instruction, the rest the previous slot.
    genvar k;
    for (k = 1; k < NS; k++) begin : g_prev
        if (k == 1) begin : g_first
            assign p_valid[k] = id_valid_i;
            assign p_we[k]    = write_en_i;
            assign p_ld[k]    = is_load_i;
            assign p_wa[k]    = write_addr_i;
        end else begin : g_rest
            assign p_valid[k] = s_valid[k-1];
            assign p_we[k]    = s_we[k-1];
            assign p_ld[k]    = s_ld[k-1];
            assign p_wa[k]    = s_wa[k-1];
        end
    end

    // RAW check against in-flight writers; WB slot is excluded because the register file bypasses it.
    always_comb begin
        raw = 1'b0;
        for (int i = 1; i < NS - 1; i++)
            if (s_valid[i] && s_we[i] && (FWD_EN == 0 || (i == 1 && s_ld[i])) &&
                ((read_en1_i && read_addr1_i != '0 && read_addr1_i == s_wa[i]) ||
                 (read_en2_i && read_addr2_i != '0 && read_addr2_i == s_wa[i])))
                raw = 1'b1;
    end

    // Control outputs with priority rst > ext_stall > flush > hazard.
    always_comb begin
        pc_stall_o = 1'b0;
        stall_o    = '0;
        clear_o    = '0;
        hazard_o   = 1'b0;
        if (rst) begin
            clear_o = ALL_ONES;
        end else if (ext_stall_i) begin
            stall_o    = ALL_ONES;
            pc_stall_o = 1'b1;
        end else if (flush_i) begin
            clear_o = FLUSH_MASK;
        end else if (raw && id_valid_i) begin
            stall_o    = NS'(1);
            clear_o    = NS'(2);
            pc_stall_o = 1'b1;
            hazard_o   = 1'b1;
        end
    end

    // Slots follow their pipeline registers: bubble on clear, hold on stall, otherwise advance.
    always_ff @(posedge clk) begin
        for (int i = 1; i < NS; i++) begin
            if (rst || clear_o[i]) begin
                s_valid[i] <= 1'b0;
            end else if (!stall_o[i]) begin
                s_valid[i] <= p_valid[i];
                s_we[i]    <= p_we[i];
                s_ld[i]    <= p_ld[i];
                s_wa[i]    <= p_wa[i];
            end
        end
    end

    // Saturating count of cycles lost to hazards.
    always_ff @(posedge clk) begin
        if (rst)
            stall_count_o <= '0;
        else if (hazard_o && stall_count_o != '1)
            stall_count_o <= stall_count_o + 1'b1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for two hazard_ctrl configurations against an in-flight queue model
module tb_hazard_ctrl;

    localparam int NS0 = 4, FW0 = 0, FD0 = 3, CW0 = 3;
    localparam int NS1 = 3, FW1 = 1, FD1 = 2, CW1 = 2;

    typedef struct {logic we; logic [4:0] wa; logic ld; int st;} rec_t;
    typedef struct {logic pc; logic [7:0] st; logic [7:0] cl; logic hz; int cnt;} exp_t;
    typedef struct {exp_t e0; exp_t e1;} pair_t;

    logic clk = 1'b0;
    logic rst, ext_stall, flush, id_valid, re1, re2, we, ld;
    logic [4:0] ra1, ra2, wa;
    logic pc0, hz0, pc1, hz1;
    logic [NS0-1:0] st0, cl0;
    logic [NS1-1:0] st1, cl1;
    logic [CW0-1:0] cnt0o;
    logic [CW1-1:0] cnt1o;

    rec_t q0[$], q1[$];
    int cnt0 = 0, cnt1 = 0;
    pair_t sb[$];
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.ADDR_WIDTH(5), .NUM_STAGES(NS0), .FWD_EN(FW0), .FLUSH_DEPTH(FD0), .CNT_WIDTH(CW0)) u0 (
        .clk(clk), .rst(rst), .id_valid_i(id_valid), .read_addr1_i(ra1), .read_addr2_i(ra2),
        .read_en1_i(re1), .read_en2_i(re2), .write_addr_i(wa), .write_en_i(we), .is_load_i(ld),
        .flush_i(flush), .ext_stall_i(ext_stall), .pc_stall_o(pc0), .stall_o(st0), .clear_o(cl0),
        .hazard_o(hz0), .stall_count_o(cnt0o));

    hazard_ctrl #(.ADDR_WIDTH(5), .NUM_STAGES(NS1), .FWD_EN(FW1), .FLUSH_DEPTH(FD1), .CNT_WIDTH(CW1)) u1 (
        .clk(clk), .rst(rst), .id_valid_i(id_valid), .read_addr1_i(ra1), .read_addr2_i(ra2),
        .read_en1_i(re1), .read_en2_i(re2), .write_addr_i(wa), .write_en_i(we), .is_load_i(ld),
        .flush_i(flush), .ext_stall_i(ext_stall), .pc_stall_o(pc1), .stall_o(st1), .clear_o(cl1),
        .hazard_o(hz1), .stall_count_o(cnt1o));

    // Expected outputs for the current inputs given the set of in-flight instructions.
    function automatic exp_t predict(input rec_t q[$], input int ns, input int fwd, input int fd, input int cnt);
        exp_t e;
        logic h;
        h = 1'b0;
        e = '{pc: 1'b0, st: 8'd0, cl: 8'd0, hz: 1'b0, cnt: cnt};
        foreach (q[i])
            if (id_valid && q[i].we && q[i].wa != 0 &&
                (fwd != 0 ? (q[i].st == 1 && q[i].ld) : (q[i].st <= ns - 2)) &&
                ((re1 && ra1 == q[i].wa) || (re2 && ra2 == q[i].wa)))
                h = 1'b1;
        if (rst) e.cl = 8'((1 << ns) - 1);
        else if (ext_stall) begin e.st = 8'((1 << ns) - 1); e.pc = 1'b1; end
        else if (flush) e.cl = 8'((1 << fd) - 1);
        else if (h) begin e.st = 8'd1; e.cl = 8'd2; e.pc = 1'b1; e.hz = 1'b1; end
        return e;
    endfunction

    // Advance the in-flight set of one configuration across a clock edge.
    task automatic step(input int c);
        rec_t q[$], nq[$];
        rec_t r;
        exp_t e;
        int ns, fwd, fd, cw, cnt;
        ns  = c == 0 ? NS0 : NS1;
        fwd = c == 0 ? FW0 : FW1;
        fd  = c == 0 ? FD0 : FD1;
        cw  = c == 0 ? CW0 : CW1;
        if (c == 0) begin q = q0; cnt = cnt0; end else begin q = q1; cnt = cnt1; end
        e = predict(q, ns, fwd, fd, cnt);
        if (rst) begin
            q.delete();
            cnt = 0;
        end else if (!ext_stall) begin
            foreach (q[i]) begin
                r = q[i];
                r.st++;
                if (r.st <= ns - 1 && !(flush && r.st < fd)) nq.push_back(r);
            end
            if (id_valid && !e.hz && !(flush && fd > 1)) nq.push_back('{we: we, wa: wa, ld: ld, st: 1});
            q = nq;
            if (e.hz && cnt < (1 << cw) - 1) cnt++;
        end
        if (c == 0) begin q0 = q; cnt0 = cnt; end else begin q1 = q; cnt1 = cnt; end
    endtask

    task automatic cyc(input logic r, input logic ex, input logic fl, input logic v,
                       input logic [4:0] a1, input logic e1, input logic [4:0] a2, input logic e2,
                       input logic [4:0] w, input logic wen, input logic l);
        @(posedge clk);
        step(0);
        step(1);
        #1;
        rst = r; ext_stall = ex; flush = fl; id_valid = v;
        ra1 = a1; re1 = e1; ra2 = a2; re2 = e2; wa = w; we = wen; ld = l;
        sb.push_back('{e0: predict(q0, NS0, FW0, FD0, cnt0), e1: predict(q1, NS1, FW1, FD1, cnt1)});
    endtask

    task automatic cmp(input string n, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
        end
    endtask

    // Monitor: every cycle the DUTs present outputs, pop the matching expectation and compare.
    always @(negedge clk) begin
        pair_t p;
        if (sb.size() > 0) begin
            p = sb.pop_front();
            cmp("u0.pc_stall", 32'(pc0), 32'(p.e0.pc));
            cmp("u0.stall", 32'(st0), 32'(p.e0.st));
            cmp("u0.clear", 32'(cl0), 32'(p.e0.cl));
            cmp("u0.hazard", 32'(hz0), 32'(p.e0.hz));
            cmp("u0.count", 32'(cnt0o), 32'(p.e0.cnt));
            cmp("u1.pc_stall", 32'(pc1), 32'(p.e1.pc));
            cmp("u1.stall", 32'(st1), 32'(p.e1.st));
            cmp("u1.clear", 32'(cl1), 32'(p.e1.cl));
            cmp("u1.hazard", 32'(hz1), 32'(p.e1.hz));
            cmp("u1.count", 32'(cnt1o), 32'(p.e1.cnt));
        end
    end

    initial begin
        rst = 1'b1; ext_stall = 1'b0; flush = 1'b0; id_valid = 1'b1;
        ra1 = '0; ra2 = '0; re1 = 1'b0; re2 = 1'b0; wa = 5'd4; we = 1'b1; ld = 1'b0;
        // reset held with a writer in decode, then idle
        cyc(1, 0, 0, 1, 0, 0, 0, 0, 4, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // load-use: lw x5, then add x6,x5,x1 held in decode
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 5, 1, 1);
        repeat (3) cyc(0, 0, 0, 1, 5, 1, 1, 1, 6, 1, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // add x7 then sub x8,x7,x7
        cyc(0, 0, 0, 1, 1, 1, 2, 1, 7, 1, 0);
        repeat (3) cyc(0, 0, 0, 1, 7, 1, 7, 1, 8, 1, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // writer to x0 then reader of x0; writer to x3 then unused x3 sources
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 0, 1, 0, 1, 9, 1, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 3, 1, 1);
        cyc(0, 0, 0, 1, 3, 0, 3, 0, 9, 1, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // flush in the same cycle as a load-use
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 5, 1, 1);
        cyc(0, 0, 1, 1, 5, 1, 0, 0, 6, 1, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // external stall over a load-use
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 5, 1, 1);
        repeat (3) cyc(0, 1, 0, 1, 5, 1, 0, 0, 6, 1, 0);
        repeat (2) cyc(0, 0, 0, 1, 5, 1, 0, 0, 6, 1, 0);
        // repeated load-use to push the counters into saturation
        repeat (8) begin
            cyc(0, 0, 0, 1, 0, 0, 0, 0, 5, 1, 1);
            cyc(0, 0, 0, 1, 5, 1, 0, 0, 6, 1, 0);
        end
        // reset mid-stall
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 5, 1, 1);
        cyc(1, 0, 0, 1, 5, 1, 0, 0, 6, 1, 0);
        cyc(0, 0, 0, 1, 5, 1, 0, 0, 6, 1, 0);
        // randomized traffic on a small register set so hazards are frequent
        repeat (4000)
            cyc($urandom % 97 == 0, $urandom % 9 == 0, $urandom % 9 == 0, $urandom % 5 != 0,
                5'($urandom % 4), $urandom % 4 != 0, 5'($urandom % 4), $urandom % 2 == 0,
                5'($urandom % 4), $urandom % 3 != 0, $urandom % 3 == 0);
        repeat (2) @(negedge clk);
        cmp("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
